// File: rtl/serial_tx_scheduler_pkg.sv
// Shared definitions for the serial transmit scheduler: state encoding and field widths.
package serial_tx_scheduler_pkg;
  localparam int BYTE_W = 8;
  localparam int LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND_LEN,
    SEND_DATA,
    GAP
  } tx_state_e;
endpackage

// File: rtl/serial_tx_scheduler_if.sv
// Source-side bundle of the scheduler: per-source request/length/byte lanes plus the link outputs.
interface serial_tx_scheduler_if import serial_tx_scheduler_pkg::*; #(
  parameter int N_REQ = 4
) ();
  logic [N_REQ-1:0]        req;
  logic [LEN_W*N_REQ-1:0]  len_in;
  logic [BYTE_W*N_REQ-1:0] byte_in;
  logic [N_REQ-1:0]        byte_ack;
  logic [N_REQ-1:0]        grant;
  logic                    Dout;
  logic                    Dout_Valid;
  logic                    busy;
  logic                    pkt_done;

  modport master (
    input  req, len_in, byte_in,
    output byte_ack, grant, Dout, Dout_Valid, busy, pkt_done
  );
  modport slave (
    output req, len_in, byte_in,
    input  byte_ack, grant, Dout, Dout_Valid, busy, pkt_done
  );
endinterface

// File: rtl/serial_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from ptr+1, wrapping.
module serial_tx_scheduler_rr_arbiter import serial_tx_scheduler_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      if (!any && req[IDX_W'((int'(ptr) + off) % N_REQ)]) begin
        any = 1'b1;
        idx = IDX_W'((int'(ptr) + off) % N_REQ);
        gnt[IDX_W'((int'(ptr) + off) % N_REQ)] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/serial_tx_scheduler.sv
// Shares one serial link among N_REQ sources; each frame is a length byte then that many
// payload bytes, LSB-first, with Dout_Valid held across the frame and a forced idle gap after.
module serial_tx_scheduler import serial_tx_scheduler_pkg::*; #(
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = 1
) (
  input logic                   tClk,
  input logic                   rst_n,
  serial_tx_scheduler_if.master bus
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  tx_state_e         state_q, state_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [LEN_W-1:0]  bytecnt_q, bytecnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  win_q, win_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              done_q, done_d;
  logic [GAP_W-1:0]  gapcnt_q, gapcnt_d;

  logic [N_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;
  logic [LEN_W-1:0]  arb_len;
  logic [BYTE_W-1:0] win_byte;
  logic              sending;
  logic              last_byte;

  serial_tx_scheduler_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req (bus.req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign arb_len   = bus.len_in[int'(arb_idx)*LEN_W +: LEN_W];
  assign win_byte  = bus.byte_in[int'(win_q)*BYTE_W +: BYTE_W];
  assign sending   = (state_q == SEND_LEN) || (state_q == SEND_DATA);
  // Length byte of a zero-length frame is also its last byte.
  assign last_byte = (state_q == SEND_LEN) ? (len_q == '0) : (bytecnt_q == len_q);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    bytecnt_d = bytecnt_q;
    len_d     = len_q;
    win_d     = win_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    ack_d     = '0;
    done_d    = 1'b0;
    gapcnt_d  = gapcnt_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          win_d    = arb_idx;
          ptr_d    = arb_idx;
          grant_d  = arb_gnt;
          len_d    = arb_len;
          shreg_d  = arb_len;
          bitcnt_d = '0;
          state_d  = SEND_LEN;
        end
      end
      SEND_LEN, SEND_DATA: begin
        shreg_d  = shreg_q >> 1;
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          if (last_byte) begin
            state_d  = GAP;
            grant_d  = '0;
            done_d   = 1'b1;
            gapcnt_d = '0;
          end else begin
            shreg_d       = win_byte;
            bytecnt_d     = (state_q == SEND_LEN) ? LEN_W'(1) : bytecnt_q + LEN_W'(1);
            ack_d[win_q]  = 1'b1;
            state_d       = SEND_DATA;
          end
        end
      end
      GAP: begin
        if (gapcnt_q == GAP_W'(GAP_CYCLES - 1)) state_d = IDLE;
        else gapcnt_d = gapcnt_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge tClk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      bytecnt_q <= '0;
      len_q     <= '0;
      win_q     <= '0;
      ptr_q     <= IDX_W'(N_REQ - 1);
      grant_q   <= '0;
      ack_q     <= '0;
      done_q    <= 1'b0;
      gapcnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      bytecnt_q <= bytecnt_d;
      len_q     <= len_d;
      win_q     <= win_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      gapcnt_q  <= gapcnt_d;
    end
  end

  assign bus.Dout       = sending & shreg_q[0];
  assign bus.Dout_Valid = sending;
  assign bus.grant      = grant_q;
  assign bus.byte_ack   = ack_q;
  assign bus.pkt_done   = done_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Random frame traffic checked cycle by cycle against a frame-level model of the link.
module tb_serial_tx_scheduler;
  localparam int N  = 4;
  localparam int G  = 1;
  localparam int IW = $clog2(N);

  logic tClk  = 1'b0;
  logic rst_n = 1'b1;

  serial_tx_scheduler_if #(.N_REQ(N)) bus ();

  serial_tx_scheduler #(.N_REQ(N), .GAP_CYCLES(G)) dut (
    .tClk  (tClk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 tClk = ~tClk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int free_at = 1;
  int mptr  = N - 1;

  // Pending packets per source; active payload of the frame each source last won.
  int         len_qs[N][$];
  logic [7:0] pay_qs[N][$];
  logic [7:0] act_pay[N][256];
  int         idx[N];
  int         dly[N];
  bit         f_on = 1'b0;
  int         f_start = 0, f_len = 0, f_w = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req[i] = (len_qs[i].size() != 0);
      bus.len_in[8*i +: 8] = (len_qs[i].size() != 0) ? 8'(len_qs[i][0]) : 8'($urandom);
      if (f_on && f_w == i && dly[i] == 0 && idx[i] < f_len)
        bus.byte_in[8*i +: 8] = act_pay[i][idx[i]];
      else
        bus.byte_in[8*i +: 8] = 8'($urandom);
    end
  endtask

  task automatic step();
    logic [N-1:0] rq, e_g, e_ack;
    logic [7:0]   cb;
    logic         e_v, e_d, e_done, e_busy, found;
    int           t, nb;
    rq = bus.req;
    @(posedge tClk);
    cyc++;
    @(negedge tClk);
    if (cyc >= free_at && rq != '0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if (!found && rq[IW'((mptr + k) % N)]) begin
          found = 1'b1;
          f_w   = (mptr + k) % N;
        end
      end
      mptr    = f_w;
      f_on    = 1'b1;
      f_start = cyc;
      f_len   = len_qs[f_w].pop_front();
      for (int b = 0; b < f_len; b++) act_pay[f_w][b] = pay_qs[f_w].pop_front();
      free_at = cyc + 8*(f_len + 1) + G + 1;
      idx[f_w] = 0;
      dly[f_w] = $urandom_range(0, 6);
    end
    e_v = 1'b0; e_d = 1'b0; e_done = 1'b0; e_busy = 1'b0; e_g = '0; e_ack = '0;
    if (f_on) begin
      t  = cyc - f_start;
      nb = 8*(f_len + 1);
      if (t < nb) begin
        cb     = (t < 8) ? 8'(f_len) : act_pay[f_w][t/8 - 1];
        e_v    = 1'b1;
        e_d    = cb[3'(t % 8)];
        e_g    = {{(N-1){1'b0}}, 1'b1} << f_w;
        e_busy = 1'b1;
        if (t >= 8 && t % 8 == 0) e_ack = e_g;
      end else if (t < nb + G) begin
        e_busy = 1'b1;
        e_done = (t == nb);
      end
    end
    chk("valid", 32'(bus.Dout_Valid), 32'(e_v));
    chk("dout",  32'(bus.Dout),       32'(e_d));
    chk("grant", 32'(bus.grant),      32'(e_g));
    chk("ack",   32'(bus.byte_ack),   32'(e_ack));
    chk("done",  32'(bus.pkt_done),   32'(e_done));
    chk("busy",  32'(bus.busy),       32'(e_busy));
    for (int i = 0; i < N; i++) begin
      if (e_ack[i]) begin
        idx[i]++;
        dly[i] = $urandom_range(0, 6);
      end else if (dly[i] > 0) dly[i]--;
    end
    drive();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.Dout_Valid), 32'd0);
    chk("rst_dout",  32'(bus.Dout),       32'd0);
    chk("rst_grant", 32'(bus.grant),      32'd0);
    chk("rst_busy",  32'(bus.busy),       32'd0);
    chk("rst_ack",   32'(bus.byte_ack),   32'd0);
    chk("rst_done",  32'(bus.pkt_done),   32'd0);
    for (int i = 0; i < N; i++) begin
      len_qs[i].delete();
      pay_qs[i].delete();
      idx[i] = 0;
      dly[i] = 0;
    end
    f_on = 1'b0;
    mptr = N - 1;
    drive();
    repeat (2) begin
      @(posedge tClk);
      cyc++;
    end
    @(negedge tClk);
    rst_n   = 1'b1;
    free_at = cyc + 1;
  endtask

  task automatic enq(input int s, input int l);
    len_qs[s].push_back(l);
    for (int b = 0; b < l; b++) pay_qs[s].push_back(8'($urandom));
    drive();
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (len_qs[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_idle(input string tag);
    int b = 0;
    while ((pending() || cyc < free_at) && b < 20000) begin
      step();
      b++;
    end
    chk(tag, 32'(b < 20000), 32'd1);
  endtask

  initial begin
    int b, l;
    for (int i = 0; i < N; i++) begin
      idx[i] = 0;
      dly[i] = 0;
    end
    drive();
    do_reset();

    len_qs[0].push_back(2);
    pay_qs[0].push_back(8'hA5);
    pay_qs[0].push_back(8'h3C);
    drive();
    run_idle("drain_a5");

    enq(1, 0);
    run_idle("drain_len0");

    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N; s++) enq(s, 1);
    run_idle("drain_rr");

    // Abort a frame from source 1 mid-payload; the pointer must restart so source 1 beats 2.
    enq(1, 20);
    b = 0;
    while (!(f_on && f_w == 1 && cyc - f_start == 8*2 + 5) && b < 500) begin
      step();
      b++;
    end
    chk("reach_midframe", 32'(b < 500), 32'd1);
    do_reset();
    enq(1, 3);
    enq(2, 2);
    run_idle("drain_after_rst");

    enq(3, 255);
    run_idle("drain_len255");

    for (int n = 0; n < 40; n++) begin
      l = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
      enq($urandom_range(0, N - 1), l);
      repeat ($urandom_range(0, 30)) step();
    end
    run_idle("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
